// File: rtl/dual_issue_scheduler.sv
// Issue-stage pair scheduler: dual-issues independent pairs, splits conflicting ones.
// Optional SCHED_PERF_EN adds dual-issue and split event counters.
module dual_issue_scheduler #(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h00000013
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] InstrA_i,
   input  logic [DATA_WIDTH-1:0] InstrB_i,
   input  logic                  ValidA_i,
   input  logic                  ValidB_i,
   input  logic                  Stall_i,
   input  logic                  Flush_i,
   output logic                  FetchReady_o,
   output logic [DATA_WIDTH-1:0] IssueInstrA_o,
   output logic [DATA_WIDTH-1:0] IssueInstrB_o,
   output logic                  IssueValidA_o,
`ifdef SCHED_PERF_EN
   output logic                  IssueValidB_o,
   output logic [31:0]           DualIssueCnt_o,
   output logic [31:0]           SplitCnt_o
`else
   output logic                  IssueValidB_o
`endif
);

   localparam logic STATE_NORMAL = 1'b0;
   localparam logic STATE_SPLIT  = 1'b1;

   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   function automatic logic writes_rd(input logic [6:0] op);
      return op inside {OP_REG, OP_IMM, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
   endfunction

   function automatic logic reads_rs1(input logic [6:0] op);
      return op inside {OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR};
   endfunction

   function automatic logic reads_rs2(input logic [6:0] op);
      return op inside {OP_REG, OP_STORE, OP_BRANCH};
   endfunction

   function automatic logic is_mem(input logic [6:0] op);
      return op inside {OP_LOAD, OP_STORE};
   endfunction

   function automatic logic is_ctrl(input logic [6:0] op);
      return op inside {OP_BRANCH, OP_JAL, OP_JALR};
   endfunction

   logic                  state_q;
   logic [DATA_WIDTH-1:0] hold_q;

   logic [6:0] op_a, op_b;
   logic [4:0] rd_a, rd_b, rs1_b, rs2_b;
   logic       reg_hazard, conflict;
   logic       advance, accept_dual, accept_split;

   assign op_a  = InstrA_i[6:0];
   assign op_b  = InstrB_i[6:0];
   assign rd_a  = InstrA_i[11:7];
   assign rd_b  = InstrB_i[11:7];
   assign rs1_b = InstrB_i[19:15];
   assign rs2_b = InstrB_i[24:20];

   // Register hazards only matter when A really produces a value (rd != x0).
   assign reg_hazard = writes_rd(op_a) && (rd_a != 5'd0) &&
                       ((reads_rs1(op_b) && (rs1_b == rd_a)) ||
                        (reads_rs2(op_b) && (rs2_b == rd_a)) ||
                        (writes_rd(op_b) && (rd_b  == rd_a)));
   assign conflict   = reg_hazard || (is_mem(op_a) && is_mem(op_b)) || is_ctrl(op_a);

   assign FetchReady_o = (state_q == STATE_NORMAL) && !Stall_i && !Flush_i;

   assign advance      = !Flush_i && !Stall_i && (state_q == STATE_NORMAL) && ValidA_i;
   assign accept_dual  = advance && ValidB_i && !conflict;
   assign accept_split = advance && ValidB_i && conflict;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= STATE_NORMAL;
         // NOTE: the hold buffer is a single register, so it is reset like any
         // other flop; a NOP value keeps it harmless if ever observed.
         hold_q        <= NOP_INSTR;
         IssueInstrA_o <= NOP_INSTR;
         IssueInstrB_o <= NOP_INSTR;
         IssueValidA_o <= 1'b0;
         IssueValidB_o <= 1'b0;
      end else if (Flush_i) begin
         state_q       <= STATE_NORMAL;
         hold_q        <= NOP_INSTR;
         IssueInstrA_o <= NOP_INSTR;
         IssueInstrB_o <= NOP_INSTR;
         IssueValidA_o <= 1'b0;
         IssueValidB_o <= 1'b0;
      end else if (!Stall_i) begin
         if (state_q == STATE_SPLIT) begin
            state_q       <= STATE_NORMAL;
            hold_q        <= NOP_INSTR;
            IssueInstrA_o <= hold_q;
            IssueInstrB_o <= NOP_INSTR;
            IssueValidA_o <= 1'b1;
            IssueValidB_o <= 1'b0;
         end else if (!ValidA_i) begin
            IssueInstrA_o <= NOP_INSTR;
            IssueInstrB_o <= NOP_INSTR;
            IssueValidA_o <= 1'b0;
            IssueValidB_o <= 1'b0;
         end else if (ValidB_i && conflict) begin
            state_q       <= STATE_SPLIT;
            hold_q        <= InstrB_i;
            IssueInstrA_o <= InstrA_i;
            IssueInstrB_o <= NOP_INSTR;
            IssueValidA_o <= 1'b1;
            IssueValidB_o <= 1'b0;
         end else begin
            IssueInstrA_o <= InstrA_i;
            IssueInstrB_o <= ValidB_i ? InstrB_i : NOP_INSTR;
            IssueValidA_o <= 1'b1;
            IssueValidB_o <= ValidB_i;
         end
      end
   end

`ifdef SCHED_PERF_EN
   // Counters survive Flush_i; only rst clears them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         DualIssueCnt_o <= 32'd0;
         SplitCnt_o     <= 32'd0;
      end else begin
         if (accept_dual)  DualIssueCnt_o <= DualIssueCnt_o + 32'd1;
         if (accept_split) SplitCnt_o     <= SplitCnt_o + 32'd1;
      end
   end
`else
   logic unused_perf;
   assign unused_perf = accept_dual ^ accept_split;
`endif

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed table-driven bench for dual_issue_scheduler plus stall/flush/reset sequences.
module tb_dual_issue_scheduler;

   localparam logic [31:0] NOP = 32'h00000013;

   typedef struct {
      logic        va, vb, stall, flush;
      logic [31:0] ia, ib;
      logic        rdy, ova, ovb;
      logic [31:0] oia, oib;
   } vec_t;

   logic        clk, rst;
   logic [31:0] instr_a, instr_b;
   logic        valid_a, valid_b, stall, flush;
   logic        fetch_ready;
   logic [31:0] issue_a, issue_b;
   logic        issue_va, issue_vb;
`ifdef SCHED_PERF_EN
   logic [31:0] dual_cnt, split_cnt;
`endif

   int checks = 0;
   int errors = 0;

   dual_issue_scheduler dut (
      .clk           (clk),
      .rst           (rst),
      .InstrA_i      (instr_a),
      .InstrB_i      (instr_b),
      .ValidA_i      (valid_a),
      .ValidB_i      (valid_b),
      .Stall_i       (stall),
      .Flush_i       (flush),
      .FetchReady_o  (fetch_ready),
      .IssueInstrA_o (issue_a),
      .IssueInstrB_o (issue_b),
      .IssueValidA_o (issue_va),
`ifdef SCHED_PERF_EN
      .IssueValidB_o (issue_vb),
      .DualIssueCnt_o(dual_cnt),
      .SplitCnt_o    (split_cnt)
`else
      .IssueValidB_o (issue_vb)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic va, vb, st, fl, input logic [31:0] ia, ib,
                               input logic rdy, ova, ovb, input logic [31:0] oia, oib);
      vec_t v;
      v.va = va; v.vb = vb; v.stall = st; v.flush = fl; v.ia = ia; v.ib = ib;
      v.rdy = rdy; v.ova = ova; v.ovb = ovb; v.oia = oia; v.oib = oib;
      return v;
   endfunction

   task automatic drive(input logic va, vb, st, fl, input logic [31:0] ia, ib);
      valid_a = va; valid_b = vb; stall = st; flush = fl; instr_a = ia; instr_b = ib;
   endtask

   task automatic check_lanes(input string tag, input logic [31:0] oia, oib,
                              input logic ova, ovb);
      check({tag, ".instr_a"}, issue_a, oia);
      check({tag, ".instr_b"}, issue_b, oib);
      check({tag, ".valid_a"}, {31'd0, issue_va}, {31'd0, ova});
      check({tag, ".valid_b"}, {31'd0, issue_vb}, {31'd0, ovb});
   endtask

   vec_t vecs[20];

   initial begin
      //            va vb st fl  instr_a       instr_b       rdy va vb  issue_a       issue_b
      vecs[0]  = mk(0, 0, 0, 0, 32'h00000000, 32'h00000000, 1, 0, 0, NOP,          NOP);
      vecs[1]  = mk(1, 1, 0, 0, 32'h00100293, 32'h00200393, 1, 1, 1, 32'h00100293, 32'h00200393);
      vecs[2]  = mk(0, 1, 0, 0, 32'h00100293, 32'h00200393, 1, 0, 0, NOP,          NOP);
      vecs[3]  = mk(1, 0, 0, 0, 32'h00100293, 32'h00528333, 1, 1, 0, 32'h00100293, NOP);
      vecs[4]  = mk(1, 1, 0, 0, 32'h00100293, 32'h00528333, 1, 1, 0, 32'h00100293, NOP);
      vecs[5]  = mk(1, 1, 0, 0, 32'h00200393, 32'h00100293, 0, 1, 0, 32'h00528333, NOP);
      vecs[6]  = mk(1, 1, 0, 0, 32'h00200393, 32'h00100293, 1, 1, 1, 32'h00200393, 32'h00100293);
      vecs[7]  = mk(1, 1, 0, 0, 32'h00100013, 32'h00000333, 1, 1, 1, 32'h00100013, 32'h00000333);
      vecs[8]  = mk(1, 1, 0, 0, 32'h00012083, 32'h00322223, 1, 1, 0, 32'h00012083, NOP);
      vecs[9]  = mk(0, 0, 0, 0, 32'h00000000, 32'h00000000, 0, 1, 0, 32'h00322223, NOP);
      vecs[10] = mk(1, 1, 0, 0, 32'h0000006f, 32'h00200393, 1, 1, 0, 32'h0000006f, NOP);
      vecs[11] = mk(0, 0, 0, 0, 32'h00000000, 32'h00000000, 0, 1, 0, 32'h00200393, NOP);
      vecs[12] = mk(1, 1, 1, 0, 32'h00100293, 32'h00200393, 0, 1, 0, 32'h00200393, NOP);
      vecs[13] = mk(1, 1, 0, 1, 32'h00100293, 32'h00200393, 0, 0, 0, NOP,          NOP);
      vecs[14] = mk(1, 1, 0, 0, 32'h00100293, 32'h00000293, 1, 1, 0, 32'h00100293, NOP);
      vecs[15] = mk(0, 0, 0, 1, 32'h00000000, 32'h00000000, 0, 0, 0, NOP,          NOP);
      vecs[16] = mk(0, 0, 0, 0, 32'h00000000, 32'h00000000, 1, 0, 0, NOP,          NOP);
      vecs[17] = mk(1, 1, 0, 0, 32'h00100293, 32'h00530333, 1, 1, 0, 32'h00100293, NOP);
      vecs[18] = mk(0, 0, 0, 0, 32'h00000000, 32'h00000000, 0, 1, 0, 32'h00530333, NOP);
      vecs[19] = mk(1, 1, 0, 0, 32'h00100293, 32'h00500313, 1, 1, 1, 32'h00100293, 32'h00500313);

      drive(0, 0, 0, 0, 32'h0, 32'h0);
      rst = 1'b1;
      #12;
      check_lanes("reset", NOP, NOP, 1'b0, 1'b0);
      check("reset.ready", {31'd0, fetch_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 20; i++) begin
         drive(vecs[i].va, vecs[i].vb, vecs[i].stall, vecs[i].flush, vecs[i].ia, vecs[i].ib);
         #1;
         check($sformatf("v%0d.ready", i), {31'd0, fetch_ready}, {31'd0, vecs[i].rdy});
         @(posedge clk);
         #1;
         check_lanes($sformatf("v%0d", i), vecs[i].oia, vecs[i].oib, vecs[i].ova, vecs[i].ovb);
         @(negedge clk);
      end

`ifdef SCHED_PERF_EN
      check("perf.dual", dual_cnt, 32'd4);
      check("perf.split", split_cnt, 32'd5);
`endif

      // Stall held in SPLIT, then flush together with stall.
      drive(1, 1, 0, 0, 32'h00100293, 32'h00528333);
      @(posedge clk); #1;
      check_lanes("ss.split", 32'h00100293, NOP, 1'b1, 1'b0);
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
         drive(1, 1, 1, 0, 32'h00200393, 32'h00100293);
         #1;
         check($sformatf("ss.stall%0d.ready", c), {31'd0, fetch_ready}, 32'd0);
         @(posedge clk); #1;
         check_lanes($sformatf("ss.stall%0d", c), 32'h00100293, NOP, 1'b1, 1'b0);
         @(negedge clk);
      end
      drive(1, 1, 1, 1, 32'h00200393, 32'h00100293);
      @(posedge clk); #1;
      check_lanes("ss.flush", NOP, NOP, 1'b0, 1'b0);
      @(negedge clk);
      drive(0, 0, 0, 0, 32'h0, 32'h0);
      #1;
      check("ss.after.ready", {31'd0, fetch_ready}, 32'd1);
      @(posedge clk); #1;
      check_lanes("ss.after", NOP, NOP, 1'b0, 1'b0);
      @(negedge clk);

      // Stall in SPLIT then release: held instruction must survive the stall.
      drive(1, 1, 0, 0, 32'h00100293, 32'h00528333);
      @(posedge clk); #1;
      @(negedge clk);
      drive(0, 0, 1, 0, 32'h0, 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      drive(0, 0, 0, 0, 32'h0, 32'h0);
      @(posedge clk); #1;
      check_lanes("sr.release", 32'h00528333, NOP, 1'b1, 1'b0);
      @(negedge clk);

      // Asynchronous reset while in SPLIT.
      drive(1, 1, 0, 0, 32'h00100293, 32'h00528333);
      @(posedge clk); #1;
      check_lanes("ar.split", 32'h00100293, NOP, 1'b1, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check_lanes("ar.async", NOP, NOP, 1'b0, 1'b0);
      check("ar.ready", {31'd0, fetch_ready}, 32'd1);
`ifdef SCHED_PERF_EN
      check("ar.dual", dual_cnt, 32'd0);
      check("ar.split_cnt", split_cnt, 32'd0);
`endif
      @(negedge clk);
      rst = 1'b0;
      drive(1, 1, 0, 0, 32'h00100293, 32'h00200393);
      @(posedge clk); #1;
      check_lanes("ar.after", 32'h00100293, 32'h00200393, 1'b1, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dual_issue_scheduler.md
Name: dual_issue_scheduler

Overview:
Issue-stage controller in front of the dual-lane decode. Accepts an instruction pair (A = older, B = younger) and checks whether both may enter decode in the same cycle. A conflicting pair is split: A issues first and B is held in a one-entry buffer, then issued alone on the following issue cycle. Outputs are registered, and fetch is back-pressured while a held instruction is pending.

Parameters:
DATA_WIDTH, 32, instruction width; only 32 is supported
NOP_INSTR, 32'h00000013, instruction driven on an idle lane (addi x0,x0,0)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
InstrA_i  in  DATA_WIDTH  older fetched instruction
InstrB_i  in  DATA_WIDTH  younger fetched instruction
ValidA_i  in  1  InstrA_i valid
ValidB_i  in  1  InstrB_i valid; ignored unless ValidA_i=1
Stall_i  in  1  backend stall; freeze all state and outputs
Flush_i  in  1  redirect; discard issued and held instructions
FetchReady_o  out  1  pair is consumed this cycle if ValidA_i=1
IssueInstrA_o  out  DATA_WIDTH  lane A instruction to decode
IssueInstrB_o  out  DATA_WIDTH  lane B instruction to decode
IssueValidA_o  out  1  lane A valid
IssueValidB_o  out  1  lane B valid

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on rst. Reset state: NORMAL, hold buffer empty, IssueInstrA_o=IssueInstrB_o=NOP_INSTR, IssueValidA_o=IssueValidB_o=0.
- Opcode classes from bits [6:0]:
  - writesRd: 0110011, 0010011, 0000011, 0110111, 0010111, 1101111, 1100111
  - readsRs1: 0110011, 0010011, 0000011, 0100011, 1100011, 1100111
  - readsRs2: 0110011, 0100011, 1100011
  - mem: 0000011, 0100011
  - ctrl: 1100011, 1101111, 1100111
- conflict is asserted when A writesRd with rdA!=0 and any of:
  - B readsRs1 and rs1B==rdA
  - B readsRs2 and rs2B==rdA
  - B writesRd and rdB==rdA
- conflict is also asserted when both A and B are mem, or when A is ctrl.
- FetchReady_o = (state==NORMAL) & ~Stall_i & ~Flush_i. This is combinational.
- Priority per cycle: Flush_i > Stall_i > normal operation.
- Flush_i: on the next edge, state=NORMAL, hold buffer cleared, both lanes NOP and invalid. The input pair is not consumed.
- Stall_i: registers hold their values and no pair is accepted.
- NORMAL state:
  - No ValidA_i: both lanes go NOP and invalid on the next edge.
  - ValidA_i, and either ValidB_i=0 or no conflict: on the next edge, lane A=InstrA_i valid and lane B=InstrB_i with IssueValidB_o=ValidB_i. If ValidB_i=0, lane B is NOP.
  - ValidA_i & ValidB_i & conflict: on the next edge, lane A=InstrA_i valid, lane B=NOP invalid, InstrB_i captured into the hold buffer, and state goes to SPLIT.
- SPLIT state (not stalled, not flushed): on the next edge, lane A=held instruction valid, lane B=NOP invalid, buffer cleared, state goes to NORMAL. The held instruction is never re-checked against the new pair, because it issues alone.
- Latency is 1 cycle from acceptance to issue. Throughput is one pair per cycle without conflicts and one pair per 2 cycles with a conflict.
- A pair that appears while the block is in SPLIT is not accepted; fetch must hold it until FetchReady_o=1.

Optional Feature:
SCHED_PERF_EN: when defined, add output DualIssueCnt_o[31:0] and output SplitCnt_o[31:0].
- DualIssueCnt_o increments on each accepted pair issued on both lanes.
- SplitCnt_o increments on each NORMAL→SPLIT transition.
- Both counters wrap at 2^32. They are cleared by rst and not by Flush_i, and are frozen during Stall_i.
When SCHED_PERF_EN is undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Independent pair: A=0x00100293 (addi x5,x0,1), B=0x00200393, both valid → next cycle both lanes valid with those instructions, FetchReady_o stays 1.
- RAW split: A=0x00100293, B=0x00528333 (add x6,x5,x5) → cycle1 lane A=0x00100293 and B invalid; FetchReady_o=0; cycle2 lane A=0x00528333 and B invalid; FetchReady_o=1.
- x0 destination: A=0x00100013, B=0x00000333 → dual issue, no split.
- Memory pair: A=0x00012083 (lw x1,0(x2)), B=0x00322223 (sw x3,4(x4)) → split; the sw issues alone on lane A the cycle after the lw.
- Stall then flush in SPLIT: after the RAW split, hold Stall_i=1 for 3 cycles → outputs frozen and held B retained. Then Flush_i=1 together with Stall_i=1 → next cycle both lanes invalid, state NORMAL, FetchReady_o=1.
- Async reset in SPLIT: assert rst between edges → outputs go to NOP and invalid immediately; after release the next valid pair issues normally. With SCHED_PERF_EN, both counters read 0.
